// File: rtl/mux_arb_nch.sv
// -----------------------------------------------------------------------------
// mux_arb_nch
// Registered N-channel, W-bit multiplexer with valid/ready handshakes.
// There are two ways to pick a channel:
//   - explicit select: mode = 0, and the channel comes from sel.
//   - round-robin:     mode = 1, scanning the valid channels from ptr.
// The output is held in a one-deep register, so the block can carry one word
// per cycle.
//
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   mode     - 0 = explicit select via sel, 1 = round-robin arbitration
//   sel      - channel index used in mode 0
//   d_in     - packed channel data, channel i at [i*WIDTH +: WIDTH]
//   d_valid  - per-channel valid
//   d_ready  - per-channel ready (combinational, at most one bit set)
//   y        - registered output data
//   y_valid  - output register holds a valid word
//   y_ready  - consumer accepts y this cycle
//   y_ch     - channel index that produced y
// -----------------------------------------------------------------------------
module mux_arb_nch #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SW    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 mode,
    input  logic [SW-1:0]        sel,
    input  logic [NCH*WIDTH-1:0] d_in,
    input  logic [NCH-1:0]       d_valid,
    output logic [NCH-1:0]       d_ready,
    output logic [WIDTH-1:0]     y,
    output logic                 y_valid,
    input  logic                 y_ready,
    output logic [SW-1:0]        y_ch
);

    localparam int            NSLOT   = 2**SW;
    localparam logic [SW:0]   NCH_EXT = (SW+1)'(NCH);
    localparam logic [SW-1:0] LAST_CH = SW'(NCH-1);

    logic [WIDTH-1:0] y_reg;
    logic             y_valid_reg;
    logic [SW-1:0]    y_ch_reg;
    logic [SW-1:0]    ptr_reg;

    // Pad the channel set out to the full select range. Any SW-bit index then
    // addresses a real slot, and the unused slots always read as not valid.
    logic [NSLOT-1:0] valid_pad;
    logic [WIDTH-1:0] slot_data [NSLOT];

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_slot
            if (gi < NCH) begin : g_real
                assign valid_pad[gi] = d_valid[gi];
                assign slot_data[gi] = d_in[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign valid_pad[gi] = 1'b0;
                assign slot_data[gi] = '0;
            end
        end
    endgenerate

    // Round-robin candidate k is ptr+k. It wraps at NCH, not at 2**SW.
    // The sum is one bit wider than SW, so it cannot overflow before the wrap.
    logic [SW-1:0] rr_cand [NCH];
    logic [NCH-1:0] rr_hit;

    generate
        for (gi = 0; gi < NCH; gi++) begin : g_rr
            logic [SW:0] sum;
            assign sum         = {1'b0, ptr_reg} + (SW+1)'(gi);
            assign rr_cand[gi] = (sum >= NCH_EXT) ? SW'(sum - NCH_EXT) : sum[SW-1:0];
            assign rr_hit[gi]  = valid_pad[rr_cand[gi]];
        end
    endgenerate

    // Priority pick: the lowest offset from ptr wins. The loop scans downward,
    // so the last assignment made is the nearest valid channel.
    logic          rr_found;
    logic [SW-1:0] rr_idx;

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (rr_hit[k]) begin
                rr_found = 1'b1;
                rr_idx   = rr_cand[k];
            end
        end
    end

    logic          sel_ok;
    logic          grant_valid;
    logic [SW-1:0] grant_idx;

    assign sel_ok = ({1'b0, sel} < NCH_EXT) && valid_pad[sel];

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        if (mode) begin
            grant_valid = rr_found;
            grant_idx   = rr_idx;
        end else begin
            grant_valid = sel_ok;
            grant_idx   = sel;
        end
    end

    logic load_en;
    logic xfer;

    assign load_en = !y_valid_reg || y_ready;
    // reset_n gates the handshake, so no producer sees ready while reset is held.
    assign xfer    = reset_n && load_en && grant_valid;

    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ready
            assign d_ready[gi] = xfer && (grant_idx == SW'(gi));
        end
    endgenerate

    logic [SW-1:0] ptr_next;
    assign ptr_next = (grant_idx == LAST_CH) ? '0 : grant_idx + SW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_reg       <= '0;
            y_valid_reg <= 1'b0;
            y_ch_reg    <= '0;
            ptr_reg     <= '0;
        end else begin
            if (xfer) begin
                y_reg       <= slot_data[grant_idx];
                y_ch_reg    <= grant_idx;
                y_valid_reg <= 1'b1;
                // The pointer moves only on round-robin grants. An explicit
                // select leaves it where round-robin last left it.
                if (mode) begin
                    ptr_reg <= ptr_next;
                end
            end else if (y_ready) begin
                // The word was consumed and nothing replaced it. Data and
                // channel keep their last values.
                y_valid_reg <= 1'b0;
            end
        end
    end

    assign y       = y_reg;
    assign y_valid = y_valid_reg;
    assign y_ch    = y_ch_reg;

endmodule

// File: doc/mux_arb_nch.md
Name: mux_arb_nch

Overview:
- Registered N-channel, W-bit multiplexer that generalises the fixed 2-to-1 combinational mux into a parametrised block.
- Sits between multiple producer ports and one consumer, for example write-back source selection or shared-bus access.
- Two modes: explicit select, or round-robin arbitration among valid channels.
- Valid/ready handshake on every port, with a one-deep output register.

Parameters:
- WIDTH, 32, data width of each channel and of the output.
- NCH, 4, number of input channels (2..16, need not be a power of two).
- SW, 2, width of the select and channel-index fields; must satisfy 2**SW >= NCH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- mode  input  1  0 = explicit select via sel; 1 = round-robin arbitration.
- sel  input  SW  channel index used when mode = 0.
- d_in  input  NCH*WIDTH  packed channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- d_valid  input  NCH  per-channel valid.
- d_ready  output  NCH  per-channel ready (combinational).
- y  output  WIDTH  registered output data.
- y_valid  output  1  output register holds a valid word.
- y_ready  input  1  consumer accepts y this cycle.
- y_ch  output  SW  index of the channel that produced the current y.

Behaviour:
- Reset (asynchronous assert, synchronous-to-clk release):
  - y = 0, y_valid = 0, y_ch = 0.
  - Round-robin pointer ptr = 0.
  - Reset mid-transfer discards the held word; no partial state survives.
- load_en = !y_valid || y_ready. The output register can take a new word only when load_en = 1.
- Grant (combinational):
  - mode 0: grant = sel if sel < NCH and d_valid[sel] = 1; otherwise no grant.
  - mode 1: grant = first i with d_valid[i] = 1, scanning ptr, ptr+1, …, NCH-1, 0, …, ptr-1 (wrap at NCH, not at 2**SW). No grant if d_valid = 0.
- d_ready[i] = load_en && grant exists && i == grant. At most one bit is set; all bits are 0 otherwise.
- Transfer occurs when d_valid[i] && d_ready[i]. On the next edge:
  - y = d_in channel i, y_ch = i, y_valid = 1.
  - In mode 1 only, ptr = (i == NCH-1) ? 0 : i+1.
- In mode 0, ptr holds its value. A later switch to mode 1 resumes from the held ptr.
- Output consumed with no transfer in the same cycle (y_valid && y_ready, no grant): y_valid = 0 next cycle; y and y_ch hold their last values.
- Simultaneous consume and transfer: the new word replaces y and y_valid stays 1, giving full throughput of 1 word/cycle.
- Backpressure (y_valid && !y_ready):
  - y, y_ch, and y_valid hold.
  - d_ready = 0.
  - ptr does not advance.
- Latency: 1 cycle from input transfer to y_valid.
- mode and sel are sampled combinationally each cycle. A change takes effect in the same cycle's grant and never corrupts a held word.
- sel >= NCH in mode 0: no grant, no transfer, no error flag.
- Fairness: in mode 1 with all channels continuously valid and y_ready = 1, grants cycle 0,1,…,NCH-1,0 with no channel skipped.
- Data path is a plain copy; no width conversion. y bits are never X after reset.

Test Plan:
- Reset check: assert reset_n = 0 mid-stream with y_valid = 1 → y = 0, y_valid = 0, y_ch = 0, d_ready = 0 immediately; after release, first mode-1 grant goes to channel 0.
- Explicit select: mode = 0, sel = 2, d_valid = 4'b1111, d_in channel k = 32'hA000_000k, y_ready = 1 → d_ready = 4'b0100; next cycle y = 32'hA000_0002, y_ch = 2, y_valid = 1; ptr unchanged.
- Round-robin fairness: mode = 1, d_valid = 4'b1111, y_ready = 1 for 8 cycles → y_ch sequence 0,1,2,3,0,1,2,3; one word per cycle, no bubbles.
- Sparse round-robin wrap: mode = 1, ptr = 3, d_valid = 4'b0101 → grant 0, then 2, then 0; ptr values 1, 3, 1.
- Backpressure: y_valid = 1, y_ready = 0 for 3 cycles with d_valid = 4'b1111 → y and y_ch stable, d_ready = 0, ptr frozen; on y_ready = 1 the next word loads in the same cycle and y_valid stays 1.
- Invalid select / idle drain: NCH = 3 instance, mode = 0, sel = 3, d_valid = 3'b111 → d_ready = 0, no transfer; a held word drains on y_ready = 1 and y_valid falls to 0 the next cycle.
